// File: rtl/tick_generator_pkg.sv
// Shared types and helpers for the tick generator.
//   tg_state_e : per-channel state (TG_RUN counting, TG_DONE one-shot finished)
//   tg_mode_e  : reload behaviour after a tick (TG_PERIODIC, TG_ONESHOT)
//   ch_w()     : width of a channel index; never narrower than one bit
package tick_gen_pkg;

  typedef enum logic {
    TG_RUN  = 1'b0,
    TG_DONE = 1'b1
  } tg_state_e;

  typedef enum logic {
    TG_PERIODIC = 1'b0,
    TG_ONESHOT  = 1'b1
  } tg_mode_e;

  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Load request channel of the tick generator.
//   load_valid/load_ready : handshake; a load is accepted when both are high
//   load_ch               : target channel index
//   load_period           : new period value
//   load_mode             : 0 periodic, 1 one-shot
//   load_err              : one-cycle pulse after an accepted load to a missing channel
interface tick_generator_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 16
);
  localparam int unsigned CH_W = tick_gen_pkg::ch_w(NUM_CH);

  logic             load_valid;
  logic [CH_W-1:0]  load_ch;
  logic [WIDTH-1:0] load_period;
  logic             load_mode;
  logic             load_ready;
  logic             load_err;

  modport master (
    output load_valid, load_ch, load_period, load_mode,
    input  load_ready, load_err
  );

  modport slave (
    input  load_valid, load_ch, load_period, load_mode,
    output load_ready, load_err
  );
endinterface

// File: rtl/tick_channel.sv
// One tick channel: down-counter that reloads from its period and emits a
// registered one-cycle tick when it expires; one-shot channels park in DONE.
//   clk_in, reset_n : clock, async active-low reset
//   enable          : count enable
//   sync            : realign RUN channel to its period (only with TICK_SYNC_EN)
//   load            : accepted load addressed to this channel
//   load_period     : period to install
//   load_mode       : mode to install
//   tick            : registered tick pulse
//   done            : channel is in DONE
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEFAULT_PERIOD = 762
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
`ifdef TICK_SYNC_EN
  input  logic             sync,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_period,
  input  tg_mode_e         load_mode,
  output logic             tick,
  output logic             done
);

  tg_state_e        state_q, state_d;
  tg_mode_e         mode_q, mode_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TG_RUN;
      mode_q   <= TG_PERIODIC;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      count_q  <= WIDTH'(DEFAULT_PERIOD);
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
    end
  end

  // Next state: load beats sync beats countdown
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    if (load) begin
      state_d  = TG_RUN;
      mode_d   = load_mode;
      period_d = load_period;
      count_d  = load_period;
    end
`ifdef TICK_SYNC_EN
    else if (sync && (state_q == TG_RUN)) begin
      count_d = period_q;
    end
`endif
    else if (enable && (state_q == TG_RUN)) begin
      if (count_q == '0) begin
        tick_d = 1'b1;
        if (mode_q == TG_ONESHOT) begin
          state_d = TG_DONE;
          count_d = '0;
        end else begin
          count_d = period_q;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  assign tick = tick_q;
  assign done = (state_q == TG_DONE);

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick generator: NUM_CH independent period counters with a
// shared load port. Optional macro TICK_SYNC_EN adds the sync realign input.
//   clk_in, reset_n : clock, async active-low reset
//   enable          : global count enable
//   sync            : realign all RUN channels (only with TICK_SYNC_EN)
//   load_if         : load request channel (slave side)
//   tick            : per-channel registered tick pulse
//   done            : per-channel DONE level
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned DEFAULT_PERIOD = 762
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              enable,
`ifdef TICK_SYNC_EN
  input  logic              sync,
`endif
  tick_generator_if.slave   load_if,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] done
);

  logic              ch_ok_c;
  logic [NUM_CH-1:0] ch_load;
  logic              load_err_q;

  // Ready whenever out of reset
  assign load_if.load_ready = reset_n;

  assign ch_ok_c = (32'(load_if.load_ch) < NUM_CH);

  // One-hot load strobe per channel
  always_comb begin
    ch_load = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (load_if.load_valid && load_if.load_ready && (32'(load_if.load_ch) == i)) begin
        ch_load[i] = 1'b1;
      end
    end
  end

  // Error pulse for an accepted load to a channel that does not exist
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_if.load_valid && !ch_ok_c;
    end
  end

  assign load_if.load_err = load_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk_in      (clk_in),
      .reset_n     (reset_n),
      .enable      (enable),
`ifdef TICK_SYNC_EN
      .sync        (sync),
`endif
      .load        (ch_load[g]),
      .load_period (load_if.load_period),
      .load_mode   (tg_mode_e'(load_if.load_mode)),
      .tick        (tick[g]),
      .done        (done[g])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench: 4-channel instance plus a 3-channel instance whose 2-bit
// load_ch can address the missing channel 3.
module tb_tick_generator;

  logic       clk_in;
  logic       reset_n;
  logic       enable;
`ifdef TICK_SYNC_EN
  logic       sync;
`endif
  logic [3:0] tick;
  logic [3:0] done;
  logic [2:0] tick3;
  logic [2:0] done3;

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;

  logic [3:0] tab_e [6] = '{4'h0, 4'hB, 4'h4, 4'h2, 4'h9, 4'h6};
  logic [3:0] et;
  logic [3:0] ed;

  tick_generator_if #(.NUM_CH(4), .WIDTH(8)) lif ();
  tick_generator_if #(.NUM_CH(3), .WIDTH(8)) lif3 ();

  tick_generator #(.NUM_CH(4), .WIDTH(8), .DEFAULT_PERIOD(2)) u_dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .enable  (enable),
`ifdef TICK_SYNC_EN
    .sync    (sync),
`endif
    .load_if (lif),
    .tick    (tick),
    .done    (done)
  );

  tick_generator #(.NUM_CH(3), .WIDTH(8), .DEFAULT_PERIOD(2)) u_dut3 (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .enable  (enable),
`ifdef TICK_SYNC_EN
    .sync    (1'b0),
`endif
    .load_if (lif3),
    .tick    (tick3),
    .done    (done3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    e++;
  endtask

  // Expected tick of the never-loaded 3-channel instance
  function automatic logic [2:0] exp3(input int k);
    if (k <= 31) return (k % 3 == 0) ? 3'h7 : 3'h0;
    if (k <= 37) return 3'h0;
    return ((k - 38) % 3 == 0) ? 3'h7 : 3'h0;
  endfunction

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
`ifdef TICK_SYNC_EN
    sync             = 1'b0;
`endif
    lif.load_valid   = 1'b0;
    lif.load_ch      = '0;
    lif.load_period  = '0;
    lif.load_mode    = 1'b0;
    lif3.load_valid  = 1'b0;
    lif3.load_ch     = '0;
    lif3.load_period = '0;
    lif3.load_mode   = 1'b0;

    repeat (2) @(posedge clk_in);
    #1;
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(lif.load_ready), 32'h0);
    check("rst_err", 32'(lif.load_err), 32'h0);
    check("rst_tick3", 32'(tick3), 32'h0);

    reset_n = 1'b1;
    enable  = 1'b1;
    #1;
    check("ready_out_of_reset", 32'(lif.load_ready), 32'h1);

    for (int k = 1; k <= 46; k++) begin
      lif.load_valid = (k == 13) || (k == 20) || (k == 31) || (k == 33);
      case (k)
        13:      begin lif.load_ch = 2'd1; lif.load_period = 8'd0; lif.load_mode = 1'b0; end
        20:      begin lif.load_ch = 2'd2; lif.load_period = 8'd4; lif.load_mode = 1'b1; end
        31:      begin lif.load_ch = 2'd2; lif.load_period = 8'd2; lif.load_mode = 1'b0; end
        33:      begin lif.load_ch = 2'd1; lif.load_period = 8'd1; lif.load_mode = 1'b0; end
        default: begin lif.load_ch = 2'd0; lif.load_period = 8'd0; lif.load_mode = 1'b0; end
      endcase
      enable           = !((k >= 32) && (k <= 36));
      lif3.load_valid  = (k == 43);
      lif3.load_ch     = 2'd3;
      lif3.load_period = 8'd0;
      step();

      if (k <= 12)      et = (k % 3 == 0) ? 4'hF : 4'h0;
      else if (k <= 19) et = ((k == 13) ? 4'h0 : 4'h2) | ((k % 3 == 0) ? 4'hD : 4'h0);
      else if (k <= 30) et = 4'h2 | ((k % 3 == 0) ? 4'h9 : 4'h0) | ((k == 25) ? 4'h4 : 4'h0);
      else if (k == 31) et = 4'h2;
      else if (k <= 36) et = 4'h0;
      else              et = tab_e[(k - 37) % 6];
      ed = ((k >= 25) && (k <= 30)) ? 4'h4 : 4'h0;

      check($sformatf("tick@%0d", k), 32'(tick), 32'(et));
      check($sformatf("done@%0d", k), 32'(done), 32'(ed));
      check($sformatf("err@%0d", k), 32'(lif.load_err), 32'h0);
      check($sformatf("tick3@%0d", k), 32'(tick3), 32'(exp3(k)));
      check($sformatf("done3@%0d", k), 32'(done3), 32'h0);
      check($sformatf("err3@%0d", k), 32'(lif3.load_err), 32'(k == 43));
    end

    // ch0 count is 0 here; an async reset must swallow the pending tick
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(lif.load_ready), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    step();
    check("rst_tick_suppressed", 32'(tick), 32'h0);
    check("rst_tick3_suppressed", 32'(tick3), 32'h0);
    @(negedge clk_in);
    reset_n = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      step();
      check($sformatf("post_rst_tick%0d", r), 32'(tick), (r == 3) ? 32'hF : 32'h0);
      check($sformatf("post_rst_tick3_%0d", r), 32'(tick3), (r == 3) ? 32'h7 : 32'h0);
      check($sformatf("post_rst_done%0d", r), 32'(done), 32'h0);
    end

`ifdef TICK_SYNC_EN
    step();
    check("sync_pre", 32'(tick), 32'h0);
    sync            = 1'b1;
    lif.load_valid  = 1'b1;
    lif.load_ch     = 2'd3;
    lif.load_period = 8'd0;
    lif.load_mode   = 1'b0;
    step();
    sync           = 1'b0;
    lif.load_valid = 1'b0;
    check("sync_edge", 32'(tick), 32'h0);
    step();
    check("sync_1", 32'(tick), 32'h8);
    step();
    check("sync_2", 32'(tick), 32'h8);
    step();
    check("sync_3", 32'(tick), 32'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
